// File: rtl/core_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : core_decode_stage
// Description : RV32I instruction decode stage. Decodes the incoming word
//               combinationally and registers the bundle into a two-entry
//               buffer (output register + skid register) so the input ready
//               is a registered signal with no path from i_ready.
//               Optional M-extension decode is enabled by defining
//               CORE_DECODE_M_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic [6:0]       o_opcode,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [2:0]       o_funct3,
    output logic [2:0]       o_imm_type,
    output logic [XLEN-1:0]  o_imm,
    output logic [3:0]       o_alu_op,
    output logic             o_reg_wr_en,
    output logic             o_mem_rd,
    output logic             o_mem_wr,
    output logic             o_branch,
    output logic             o_jump,
    output logic             o_mul_div,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_REG    = 7'b0110011;
    localparam logic [6:0] C_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] C_IMM_U = 3'b000;
    localparam logic [2:0] C_IMM_I = 3'b001;
    localparam logic [2:0] C_IMM_S = 3'b010;
    localparam logic [2:0] C_IMM_B = 3'b011;
    localparam logic [2:0] C_IMM_J = 3'b100;

    localparam logic [3:0] C_ALU_ADD  = 4'b0000;
    localparam logic [3:0] C_ALU_SUB  = 4'b1000;
    localparam logic [3:0] C_ALU_IN_2 = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            reg_wr_en;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            mul_div;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    bundle_t          r_out;
    bundle_t          r_skid;
    bundle_t          w_dec;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic [31:0]      w_imm32;
    logic [6:0]       w_funct7;
    logic [2:0]       w_funct3;
    logic             w_accept;
    logic             w_xfer;
    logic             w_load_out_dec;
    logic             w_load_out_skid;
    logic             w_load_skid;

    assign w_funct7 = i_instruction[31:25];
    assign w_funct3 = i_instruction[14:12];
    assign w_accept = i_valid & r_in_ready;
    assign w_xfer   = (r_state != ST_EMPTY) & i_ready;

    // Combinational decode of the incoming instruction word
    always_comb begin
        w_dec          = '0;
        w_imm32        = '0;
        w_dec.pc       = i_pc;
        w_dec.opcode   = i_instruction[6:0];
        w_dec.rs1      = i_instruction[19:15];
        w_dec.rs2      = i_instruction[24:20];
        w_dec.funct3   = w_funct3;
        w_dec.imm_type = C_IMM_I;
        w_dec.alu_op   = C_ALU_ADD;

        case (i_instruction[6:0])
            C_OP_LUI: begin
                w_dec.imm_type  = C_IMM_U;
                w_dec.alu_op    = C_ALU_IN_2;
                w_dec.reg_wr_en = 1'b1;
            end
            C_OP_AUIPC: begin
                w_dec.imm_type  = C_IMM_U;
                w_dec.reg_wr_en = 1'b1;
            end
            C_OP_JAL: begin
                w_dec.imm_type  = C_IMM_J;
                w_dec.jump      = 1'b1;
                w_dec.reg_wr_en = 1'b1;
            end
            C_OP_JALR: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_wr_en = 1'b1;
                w_dec.illegal   = (w_funct3 != 3'b000);
            end
            C_OP_BRANCH: begin
                w_dec.imm_type = C_IMM_B;
                w_dec.branch   = 1'b1;
                w_dec.alu_op   = C_ALU_SUB;
                w_dec.illegal  = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            C_OP_LOAD: begin
                w_dec.mem_rd    = 1'b1;
                w_dec.reg_wr_en = 1'b1;
            end
            C_OP_STORE: begin
                w_dec.imm_type = C_IMM_S;
                w_dec.mem_wr   = 1'b1;
            end
            C_OP_IMM: begin
                w_dec.reg_wr_en = 1'b1;
                w_dec.alu_op    = {w_funct7[5] & (w_funct3 == 3'b101), w_funct3};
            end
            C_OP_REG: begin
                w_dec.reg_wr_en = 1'b1;
                w_dec.alu_op    = {w_funct7[5], w_funct3};
                if (w_funct7 == 7'b0000000) begin
                    w_dec.illegal = 1'b0;
                end else if ((w_funct7 == 7'b0100000) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                    w_dec.illegal = 1'b0;
`ifdef CORE_DECODE_M_EXT_EN
                end else if (w_funct7 == 7'b0000001) begin
                    // funct3 passes through unchanged to pick MUL..REMU
                    w_dec.mul_div = 1'b1;
                    w_dec.alu_op  = C_ALU_ADD;
`endif
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            C_OP_FENCE, C_OP_SYSTEM: begin
                w_dec.illegal = 1'b0;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase

        // Compressed-encoding space is not supported
        if (i_instruction[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end

        // An illegal instruction must not cause any side effect downstream
        if (w_dec.illegal) begin
            w_dec.reg_wr_en = 1'b0;
            w_dec.mem_rd    = 1'b0;
            w_dec.mem_wr    = 1'b0;
            w_dec.branch    = 1'b0;
            w_dec.jump      = 1'b0;
            w_dec.mul_div   = 1'b0;
        end

        w_dec.rd = w_dec.reg_wr_en ? i_instruction[11:7] : 5'd0;

        case (w_dec.imm_type)
            C_IMM_U: w_imm32 = {i_instruction[31:12], 12'b0};
            C_IMM_S: w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25],
                                i_instruction[11:7]};
            C_IMM_B: w_imm32 = {{19{i_instruction[31]}}, i_instruction[31],
                                i_instruction[7], i_instruction[30:25],
                                i_instruction[11:8], 1'b0};
            C_IMM_J: w_imm32 = {{11{i_instruction[31]}}, i_instruction[31],
                                i_instruction[19:12], i_instruction[20],
                                i_instruction[30:21], 1'b0};
            default: w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
        endcase
        w_dec.imm = XLEN'($signed(w_imm32));
    end

    // Buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer next-state and load-enable decode
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_dec  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_out_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_load_out_dec = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_xfer) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Output and skid registers plus registered input ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_load_out_dec) begin
                r_out <= w_dec;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Saturating count of accepted illegal instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_dec.illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign o_ready       = r_in_ready;
    assign o_valid       = (r_state != ST_EMPTY);
    assign o_pc          = r_out.pc;
    assign o_opcode      = r_out.opcode;
    assign o_rd          = r_out.rd;
    assign o_rs1         = r_out.rs1;
    assign o_rs2         = r_out.rs2;
    assign o_funct3      = r_out.funct3;
    assign o_imm_type    = r_out.imm_type;
    assign o_imm         = r_out.imm;
    assign o_alu_op      = r_out.alu_op;
    assign o_reg_wr_en   = r_out.reg_wr_en;
    assign o_mem_rd      = r_out.mem_rd;
    assign o_mem_wr      = r_out.mem_wr;
    assign o_branch      = r_out.branch;
    assign o_jump        = r_out.jump;
    assign o_mul_div     = r_out.mul_div;
    assign o_illegal     = r_out.illegal;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: doc/core_decode_stage.md
CORE_DECODE_STAGE -- requirements
Module: core_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of illegal-instruction counter.
REQ-003 Clk  input  1  sole clock, all state on rising edge.
REQ-004 Rst_N  input  1  reset, asynchronous, active-low.
REQ-005 InValid  input  1  upstream instruction valid.
REQ-006 InReady  output  1  stage can accept instruction.
REQ-007 Instruction  input  32  raw RV32 instruction word.
REQ-008 InPc  input  XLEN  instruction PC.
REQ-009 OutValid  output  1  decoded bundle valid.
REQ-010 OutReady  input  1  downstream accepts bundle.
REQ-011 OutPc  output  XLEN  registered PC.
REQ-012 Opcode  output  7  instruction[6:0].
REQ-013 Rd, Rs1, Rs2  output  5 each  register indices.
REQ-014 Funct3  output  3  instruction[14:12].
REQ-015 ImmType  output  3  U=000, I=001, S=010, B=011, J=100.
REQ-016 Imm  output  XLEN  sign-extended immediate.
REQ-017 AluOp  output  4  ADD=0000, SUB=1000, SLT=0010, SLTU=0011, SLL=0001, SRL=0101, SRA=1101, XOR=0100, OR=0110, AND=0111, IN_2=1111.
REQ-018 RegWrEn, MemRd, MemWr, Branch, Jump, MulDiv, Illegal  output  1 each  control flags.
REQ-019 IllegalCnt  output  CNT_W  count of illegal instructions accepted.

Function
REQ-020 SHALL decode combinationally from Instruction and register result into a 2-entry buffer (output register + skid register); latency exactly 1 cycle when OutReady=1.
REQ-021 Transfer occurs on valid&ready at either port; OutValid and bundle SHALL stay stable while OutValid=1 and OutReady=0.
REQ-022 Buffer states: EMPTY, ONE (output reg full), TWO (both full); InReady=1 in EMPTY/ONE, 0 in TWO; InReady SHALL be registered (no combinational path from OutReady).
REQ-023 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without output transfer; ONE->EMPTY on output transfer without accept; ONE stays on simultaneous accept+transfer (new bundle replaces output reg); TWO->ONE on output transfer (skid moves to output reg).
REQ-024 Immediates: I={31:20}; S={31:25,11:7}; B={31,7,30:25,11:8,0}; J={31,19:12,20,30:21,0}; U={31:12,12'b0}; all sign-extended from bit 31 to XLEN.
REQ-025 Opcode map: LUI 0110111 (U, AluOp=IN_2, RegWrEn); AUIPC 0010111 (U, ADD, RegWrEn); JAL 1101111 (J, Jump, RegWrEn); JALR 1100111 (I, Jump, RegWrEn, funct3 must be 000); BRANCH 1100011 (B, Branch, funct3 in {000,001,100,101,110,111}, AluOp=SUB); LOAD 0000011 (I, MemRd, RegWrEn, ADD); STORE 0100011 (S, MemWr, ADD); I_OP 0010011 (I, AluOp={funct7[5]&funct3==101, funct3}); R_OP 0110011 (AluOp={funct7[5],funct3}); FENCE 0001111 and SYSCAL 1110011 decode as no-op (all flags 0, not illegal).
REQ-026 Illegal=1 for unlisted opcode, bad JALR/BRANCH funct3, R_OP funct7 not in {0000000, 0100000 with funct3 000/101}, or Instruction[1:0]!=11; when Illegal=1 RegWrEn, MemRd, MemWr, Branch, Jump, MulDiv SHALL be 0.
REQ-027 IllegalCnt SHALL increment by 1 per accepted illegal instruction and saturate at all-ones.
REQ-028 Rd SHALL be forced to 0 when RegWrEn=0.

Reset
REQ-029 On Rst_N=0 (asynchronous): buffer EMPTY, OutValid=0, InReady=1, all bundle outputs 0, IllegalCnt=0; reset mid-transfer SHALL discard both entries.
REQ-030 First accept SHALL be possible on the first rising edge after Rst_N deasserts.

Configuration
REQ-031 Macro CORE_DECODE_M_EXT_EN: when defined, R_OP with funct7=0000001 is legal, MulDiv=1, RegWrEn=1, AluOp=ADD, Funct3 selects MUL..REMU.
REQ-032 Without CORE_DECODE_M_EXT_EN, funct7=0000001 R_OP SHALL be Illegal and MulDiv SHALL be constant 0.

Verification
REQ-033 Reset, then Instruction=0x00500093 (addi x1,x0,5), OutReady=1 -> next cycle OutValid=1, Rd=1, Imm=5, AluOp=0000, ImmType=001, RegWrEn=1.
REQ-034 Instruction=0xFE000EE3 (beq, offset -4) -> Imm=0xFFFFFFFC, Branch=1, ImmType=011, Rd=0.
REQ-035 OutReady=0, three back-to-back InValid -> two accepted, InReady=0 after second; raise OutReady -> bundles emerge in order, no loss or duplication.
REQ-036 Instruction=0x02208033 (mul) -> with macro MulDiv=1, Illegal=0; without macro Illegal=1, IllegalCnt increments to 1.
REQ-037 XLEN=64, Instruction=0x800000B7 (lui x1,0x80000) -> Imm=0xFFFFFFFF80000000, AluOp=1111.
REQ-038 Assert Rst_N=0 while buffer in TWO -> OutValid=0, InReady=1, IllegalCnt=0 immediately, before next clock edge.
